lane_demand_sensor: RTL

- Upstream stage that produces the traffic controller's lane-count bus and its emergency request inputs.
- Keeps a per-lane queued-car count for eight lanes: increments on arrival pulses, drains while the lane is green.
- Arbitrates per-lane emergency transponder levels into a single latched emgSignal/emgLane pair with a hold-off timer.
- Outputs connect directly to the controller's lanes, emgSignal and emgLane inputs.

---
 rtl/lane_demand_sensor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lane_demand_sensor.sv
// Per-lane queued-car counters with green-time drain and an emergency grant FSM.
// Define LANE_OVF_FLAG_EN to add the sticky per-lane ovfFlag output.
module lane_demand_sensor #(
    parameter int DRAIN_PERIOD = 4,
    parameter int EMG_HOLD     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  arrive,
    input  logic [7:0]  green,
    input  logic [7:0]  emgSense,
    output logic [63:0] lanes,
    output logic        emgSignal,
`ifdef LANE_OVF_FLAG_EN
    output logic [7:0]  ovfFlag,
`endif
    output logic [7:0]  emgLane
);

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_PERIOD - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(EMG_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLD
    } emg_state_t;

    logic [7:0][7:0] count;
    logic [7:0][7:0] timer;
    logic [7:0]      depart;
    logic [7:0]      pick;
    logic            granted_live;
    emg_state_t      state;
    logic [7:0]      hold_cnt;

    assign lanes = count;

    always_comb begin
        depart = '0;
        for (int i = 0; i < 8; i++) begin
            depart[i] = green[i] && (timer[i] == DRAIN_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            timer <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (!green[i] || depart[i]) begin
                    timer[i] <= 8'd0;
                end else begin
                    timer[i] <= timer[i] + 8'd1;
                end
                if (arrive[i] && !depart[i] && count[i] != 8'hFF) begin
                    count[i] <= count[i] + 8'd1;
                end else if (depart[i] && !arrive[i] && count[i] != 8'h00) begin
                    count[i] <= count[i] - 8'd1;
                end
            end
        end
    end

`ifdef LANE_OVF_FLAG_EN
    // Sticky: a dropped arrival on a full lane is remembered until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovfFlag <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (arrive[i] && !depart[i] && count[i] == 8'hFF) begin
                    ovfFlag[i] <= 1'b1;
                end
            end
        end
    end
`endif

    // Ascending scan so the highest set sensor bit wins.
    always_comb begin
        pick = '0;
        for (int i = 0; i < 8; i++) begin
            if (emgSense[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

    assign granted_live = |(emgSense & emgLane);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hold_cnt  <= 8'd0;
            emgSignal <= 1'b0;
            emgLane   <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (emgSense != 8'h00) begin
                        emgLane   <= pick;
                        emgSignal <= 1'b1;
                        state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!granted_live) begin
                        hold_cnt <= HOLD_LOAD;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (granted_live) begin
                        state <= ACTIVE;
                    end else if (hold_cnt == 8'd0) begin
                        emgSignal <= 1'b0;
                        emgLane   <= 8'h00;
                        state     <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
